// File: rtl/dec_gpr_wb_ctl.sv
// GPR writeback controller: the ALU writes straight through, and FPU results drain in order from a FIFO
// when the ALU is idle. A busy scoreboard on FPU destinations drives the read-after-write stalls.
module dec_gpr_wb_ctl #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        alu_wb_valid,
    input  logic [4:0]                  alu_wb_rd,
    input  logic [XLEN-1:0]             alu_wb_data,
    input  logic                        fpu_wb_valid,
    output logic                        fpu_wb_ready,
    input  logic [4:0]                  fpu_wb_rd,
    input  logic [XLEN-1:0]             fpu_wb_data,
    input  logic                        fpu_issue_valid,
    input  logic [4:0]                  fpu_issue_rd,
    input  logic [4:0]                  raddr0,
    input  logic [4:0]                  raddr1,
    output logic                        stall0,
    output logic                        stall1,
    output logic                        wen0,
    output logic [4:0]                  waddr0,
    output logic [XLEN-1:0]             wd0,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      fifo_rd_r   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [31:0]     busy_r;
    logic            wen_r;
    logic            wb_is_fpu_r;
    logic [4:0]      waddr_r;
    logic [XLEN-1:0] wd_r;

    logic            push_s;
    logic            pop_s;
    logic            wen_s;
    logic            is_fpu_s;
    logic [4:0]      waddr_s;
    logic [XLEN-1:0] wd_s;
    logic [31:0]     set_s;
    logic [31:0]     clr_s;
    logic [31:0]     busy_s;

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign fpu_wb_ready = ~rst_l & (count_r < CW'(FIFO_DEPTH));
    assign push_s       = fpu_wb_valid & fpu_wb_ready;
    assign pop_s        = (count_r != {CW{1'b0}}) & ~alu_wb_valid;

    assign stall0     = (raddr0 != 5'd0) & busy_r[raddr0];
    assign stall1     = (raddr1 != 5'd0) & busy_r[raddr1];
    assign wen0       = wen_r;
    assign waddr0     = waddr_r;
    assign wd0        = wd_r;
    assign fifo_count = count_r;

    // Select the next write-port source: the ALU wins, otherwise the FIFO head.
    always_comb begin
        wen_s    = 1'b0;
        waddr_s  = 5'd0;
        wd_s     = {XLEN{1'b0}};
        is_fpu_s = 1'b0;
        if (alu_wb_valid) begin
            wen_s    = (alu_wb_rd != 5'd0);
            waddr_s  = alu_wb_rd;
            wd_s     = alu_wb_data;
            is_fpu_s = 1'b0;
        end else if (pop_s) begin
            wen_s    = (fifo_rd_r[rd_ptr_r] != 5'd0);
            waddr_s  = fifo_rd_r[rd_ptr_r];
            wd_s     = fifo_data_r[rd_ptr_r];
            is_fpu_s = 1'b1;
        end else begin
            wen_s    = 1'b0;
            is_fpu_s = 1'b0;
        end
    end

    // Scoreboard update: an FPU write on the port clears its bit, and a new issue sets one (set wins).
    always_comb begin
        clr_s  = (wen_r & wb_is_fpu_r) ? (32'd1 << waddr_r) : 32'd0;
        set_s  = (fpu_issue_valid & (fpu_issue_rd != 5'd0)) ? (32'd1 << fpu_issue_rd) : 32'd0;
        busy_s = (busy_r & ~clr_s) | set_s;
    end

    // FIFO storage has no reset; validity is tracked only by the pointers and the count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= fpu_wb_rd;
            fifo_data_r[wr_ptr_r] <= fpu_wb_data;
        end
    end

    // Control state: the write-port registers, FIFO pointers and count, and the scoreboard.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            wen_r       <= 1'b0;
            wb_is_fpu_r <= 1'b0;
            waddr_r     <= 5'd0;
            wd_r        <= {XLEN{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            busy_r      <= 32'd0;
        end else begin
            wen_r       <= wen_s;
            wb_is_fpu_r <= is_fpu_s;
            waddr_r     <= waddr_s;
            wd_r        <= wd_s;
            busy_r      <= busy_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_dec_gpr_wb_ctl.sv
// Testbench for dec_gpr_wb_ctl: directed scenarios plus randomized traffic, checked against
// a queue-based reference model.
module tb_dec_gpr_wb_ctl;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        fpu_wb_valid;
    logic        fpu_wb_ready;
    logic [4:0]  fpu_wb_rd;
    logic [31:0] fpu_wb_data;
    logic        fpu_issue_valid;
    logic [4:0]  fpu_issue_rd;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic        stall0;
    logic        stall1;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wd0;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    dec_gpr_wb_ctl #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .fpu_wb_valid(fpu_wb_valid), .fpu_wb_ready(fpu_wb_ready),
        .fpu_wb_rd(fpu_wb_rd), .fpu_wb_data(fpu_wb_data),
        .fpu_issue_valid(fpu_issue_valid), .fpu_issue_rd(fpu_issue_rd),
        .raddr0(raddr0), .raddr1(raddr1), .stall0(stall0), .stall1(stall1),
        .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    res_t        mq[$];
    bit          m_busy[32];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wd;
    bit          m_wbfpu;
    int          checks = 0;
    int          errors = 0;

    function automatic bit exp_stall(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a];
    endfunction

    task automatic idle_inputs();
        alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'd0;
        fpu_wb_valid = 1'b0; fpu_wb_rd = 5'd0; fpu_wb_data = 32'd0;
        fpu_issue_valid = 1'b0; fpu_issue_rd = 5'd0;
        raddr0 = 5'd0; raddr1 = 5'd0;
    endtask

    // Advance the model by one clock using the current inputs, then move to the next falling edge.
    task automatic step();
        res_t e;
        bit   acc;
        if (rst_l) begin
            mq.delete();
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_wen = 1'b0; m_waddr = 5'd0; m_wd = 32'd0; m_wbfpu = 1'b0;
        end else begin
            acc = fpu_wb_valid && (mq.size() < DEPTH);
            if (m_wen && m_wbfpu) m_busy[m_waddr] = 1'b0;
            if (fpu_issue_valid && fpu_issue_rd != 5'd0) m_busy[fpu_issue_rd] = 1'b1;
            if (alu_wb_valid) begin
                m_wen = (alu_wb_rd != 5'd0); m_waddr = alu_wb_rd; m_wd = alu_wb_data; m_wbfpu = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wen = (e.rd != 5'd0); m_waddr = e.rd; m_wd = e.data; m_wbfpu = 1'b1;
            end else begin
                m_wen = 1'b0; m_wbfpu = 1'b0;
            end
            if (acc) begin
                e.rd = fpu_wb_rd; e.data = fpu_wb_data;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_l = 1'b1;
        step();
        step();
        checks++;
        if (wen0 !== 1'b0) begin errors++; $display("FAIL reset_wen0: got %0h want 0", wen0); end
        checks++;
        if (waddr0 !== 5'd0 || wd0 !== 32'd0) begin
            errors++; $display("FAIL reset_wport: got waddr0=%0h wd0=%0h want 0/0", waddr0, wd0);
        end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++;
        if (fpu_wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0h want 0", fpu_wb_ready); end
        rst_l = 1'b0;
        #1;
        checks++;
        if (fpu_wb_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0h want 1", fpu_wb_ready); end
    endtask

    task automatic test_alu();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h0000_3C00;
        step();
        checks++;
        if (wen0 !== 1'b1 || waddr0 !== 5'd5 || wd0 !== 32'h0000_3C00) begin
            errors++; $display("FAIL alu_write: got wen0=%0h waddr0=%0d wd0=%0h want 1/5/3c00", wen0, waddr0, wd0);
        end
        idle_inputs();
        step();
        checks++;
        if (wen0 !== 1'b0) begin errors++; $display("FAIL alu_one_cycle: got wen0=%0h want 0", wen0); end
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = $urandom;
        step();
        checks++;
        if (wen0 !== 1'b0) begin errors++; $display("FAIL alu_rd0: got wen0=%0h want 0", wen0); end
        idle_inputs();
        step();
    endtask

    task automatic test_fpu_latency();
        fpu_issue_valid = 1'b1; fpu_issue_rd = 5'd7;
        step();
        idle_inputs();
        raddr0 = 5'd7;
        #1;
        checks++;
        if (stall0 !== 1'b1) begin errors++; $display("FAIL lat_stall_c2: got %0h want 1", stall0); end
        step();
        fpu_wb_valid = 1'b1; fpu_wb_rd = 5'd7; fpu_wb_data = 32'h0000_4200;
        #1;
        checks++;
        if (stall0 !== 1'b1 || fpu_wb_ready !== 1'b1) begin
            errors++; $display("FAIL lat_c3: got stall0=%0h ready=%0h want 1/1", stall0, fpu_wb_ready);
        end
        step();
        fpu_wb_valid = 1'b0;
        #1;
        checks++;
        if (stall0 !== 1'b1 || wen0 !== 1'b0 || fifo_count !== 3'd1) begin
            errors++; $display("FAIL lat_c4: got stall0=%0h wen0=%0h count=%0d want 1/0/1", stall0, wen0, fifo_count);
        end
        step();
        checks++;
        if (wen0 !== 1'b1 || waddr0 !== 5'd7 || wd0 !== 32'h0000_4200 || stall0 !== 1'b1) begin
            errors++;
            $display("FAIL lat_c5: got wen0=%0h waddr0=%0d wd0=%0h stall0=%0h want 1/7/4200/1", wen0, waddr0, wd0, stall0);
        end
        step();
        checks++;
        if (stall0 !== 1'b0 || wen0 !== 1'b0) begin
            errors++; $display("FAIL lat_c6: got stall0=%0h wen0=%0h want 0/0", stall0, wen0);
        end
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        res_t r[5];
        int   k = 0;
        int   idx = 0;
        int   cyc = 0;
        bit   acc;
        for (int i = 0; i < 5; i++) begin
            r[i].rd = 5'($urandom_range(1, 31)); r[i].data = $urandom;
        end
        for (int c = 0; c < 8; c++) begin
            alu_wb_valid = 1'b1; alu_wb_rd = 5'($urandom_range(0, 31)); alu_wb_data = $urandom;
            fpu_wb_valid = (k < 5);
            if (k < 5) begin fpu_wb_rd = r[k].rd; fpu_wb_data = r[k].data; end
            #1;
            checks++;
            if (fpu_wb_ready !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL bp_ready: got %0h want %0h", fpu_wb_ready, mq.size() < DEPTH);
            end
            acc = (k < 5) && (mq.size() < DEPTH);
            step();
            if (acc) k++;
            checks++;
            if (wen0 !== m_wen || (m_wen && (waddr0 !== m_waddr || wd0 !== m_wd))) begin
                errors++; $display("FAIL bp_alu_write: got %0h/%0d/%0h want %0h/%0d/%0h", wen0, waddr0, wd0, m_wen, m_waddr, m_wd);
            end
        end
        checks++;
        if (fifo_count !== 3'd4 || fpu_wb_ready !== 1'b0 || k != 4) begin
            errors++; $display("FAIL bp_full: got count=%0d ready=%0h accepted=%0d want 4/0/4", fifo_count, fpu_wb_ready, k);
        end
        alu_wb_valid = 1'b0;
        while (idx < 5 && cyc < 30) begin
            fpu_wb_valid = (k < 5);
            if (k < 5) begin fpu_wb_rd = r[k].rd; fpu_wb_data = r[k].data; end
            #1;
            acc = (k < 5) && (mq.size() < DEPTH);
            step();
            cyc++;
            if (acc) k++;
            checks++;
            if (fifo_count !== 3'(mq.size())) begin
                errors++; $display("FAIL bp_drain_count: got %0d want %0d", fifo_count, mq.size());
            end
            if (wen0 === 1'b1) begin
                checks++;
                if (waddr0 !== r[idx].rd || wd0 !== r[idx].data) begin
                    errors++; $display("FAIL bp_order: got %0d/%0h want %0d/%0h", waddr0, wd0, r[idx].rd, r[idx].data);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 5) begin errors++; $display("FAIL bp_drain_timeout: got %0d writes want 5", idx); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        res_t r[10];
        int   k = 0;
        int   idx = 0;
        int   cyc = 0;
        bit   acc;
        for (int i = 0; i < 10; i++) begin
            r[i].rd = 5'($urandom_range(1, 31)); r[i].data = $urandom;
        end
        while (idx < 10 && cyc < 40) begin
            fpu_wb_valid = (k < 10);
            if (k < 10) begin fpu_wb_rd = r[k].rd; fpu_wb_data = r[k].data; end
            #1;
            acc = (k < 10) && (mq.size() < DEPTH);
            step();
            cyc++;
            if (acc) k++;
            checks++;
            if (fifo_count > 3'd4 || fifo_count !== 3'(mq.size())) begin
                errors++; $display("FAIL wrap_count: got %0d want %0d", fifo_count, mq.size());
            end
            if (wen0 === 1'b1) begin
                checks++;
                if (waddr0 !== r[idx].rd || wd0 !== r[idx].data) begin
                    errors++; $display("FAIL wrap_order: got %0d/%0h want %0d/%0h", waddr0, wd0, r[idx].rd, r[idx].data);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 10) begin errors++; $display("FAIL wrap_timeout: got %0d writes want 10", idx); end
        idle_inputs();
    endtask

    task automatic test_collision();
        fpu_issue_valid = 1'b1; fpu_issue_rd = 5'd9;
        step();
        idle_inputs();
        fpu_wb_valid = 1'b1; fpu_wb_rd = 5'd9; fpu_wb_data = $urandom;
        step();
        idle_inputs();
        step();
        fpu_issue_valid = 1'b1; fpu_issue_rd = 5'd9; raddr1 = 5'd9;
        #1;
        checks++;
        if (wen0 !== 1'b1 || waddr0 !== 5'd9 || stall1 !== 1'b1) begin
            errors++; $display("FAIL coll_setup: got wen0=%0h waddr0=%0d stall1=%0h want 1/9/1", wen0, waddr0, stall1);
        end
        step();
        fpu_issue_valid = 1'b0;
        #1;
        checks++;
        if (stall1 !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got stall1=%0h want 1", stall1); end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        fpu_issue_valid = 1'b1; fpu_issue_rd = 5'd3;
        step();
        fpu_issue_rd = 5'd4;
        step();
        fpu_issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_wb_valid = 1'b1; alu_wb_rd = 5'($urandom_range(1, 31)); alu_wb_data = $urandom;
            fpu_wb_valid = 1'b1; fpu_wb_rd = (i == 0) ? 5'd3 : 5'd4; fpu_wb_data = $urandom;
            step();
        end
        fpu_wb_valid = 1'b0;
        raddr0 = 5'd3; raddr1 = 5'd4;
        #1;
        checks++;
        if (fifo_count !== 3'd3 || stall0 !== 1'b1 || stall1 !== 1'b1) begin
            errors++; $display("FAIL mrst_pre: got count=%0d stall=%0h%0h want 3/11", fifo_count, stall0, stall1);
        end
        alu_wb_valid = 1'b0;
        rst_l = 1'b1;
        step();
        rst_l = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 3'd0 || wen0 !== 1'b0 || stall0 !== 1'b0 || stall1 !== 1'b0) begin
            errors++; $display("FAIL mrst_post: got count=%0d wen0=%0h stall=%0h%0h want 0/0/00", fifo_count, wen0, stall0, stall1);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (wen0 !== 1'b0) begin errors++; $display("FAIL mrst_ghost_write: got wen0=1 waddr0=%0d want no write", waddr0); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_l           = ($urandom_range(0, 63) == 0);
            alu_wb_valid    = ($urandom_range(0, 2) == 0);
            alu_wb_rd       = 5'($urandom_range(0, 31));
            alu_wb_data     = $urandom;
            fpu_wb_valid    = ($urandom_range(0, 1) == 0);
            fpu_wb_rd       = 5'($urandom_range(0, 31));
            fpu_wb_data     = $urandom;
            fpu_issue_valid = ($urandom_range(0, 3) == 0);
            fpu_issue_rd    = 5'($urandom_range(0, 31));
            raddr0          = 5'($urandom_range(0, 31));
            raddr1          = 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (stall0 !== exp_stall(raddr0) || stall1 !== exp_stall(raddr1)) begin
                errors++; $display("FAIL rnd_stall: got %0h%0h want %0h%0h", stall0, stall1, exp_stall(raddr0), exp_stall(raddr1));
            end
            checks++;
            if (fpu_wb_ready !== (!rst_l && mq.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_ready: got %0h want %0h", fpu_wb_ready, (!rst_l && mq.size() < DEPTH));
            end
            step();
            checks++;
            if (wen0 !== m_wen || (m_wen && (waddr0 !== m_waddr || wd0 !== m_wd))) begin
                errors++; $display("FAIL rnd_write: got %0h/%0d/%0h want %0h/%0d/%0h", wen0, waddr0, wd0, m_wen, m_waddr, m_wd);
            end
            checks++;
            if (fifo_count !== 3'(mq.size())) begin
                errors++; $display("FAIL rnd_count: got %0d want %0d", fifo_count, mq.size());
            end
        end
        rst_l = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_l = 1'b1;
        @(negedge clk);
        test_reset();
        test_alu();
        test_fpu_latency();
        test_back_pressure();
        test_wrap();
        test_collision();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_gpr_wb_ctl.md
Name: dec_gpr_wb_ctl

Overview:
Writeback controller that drives the single write port (wen0/waddr0/wd0) of the GPR file, which has 31 registers; x0 is never written.
- Merges two result sources: the single-cycle integer ALU, which is always accepted, and the multi-cycle FPU, which uses a valid/ready handshake and is buffered in a FIFO.
- Keeps a per-register busy scoreboard for outstanding FPU destinations and reports read-after-write stalls for the two GPR read addresses.

Parameters:
XLEN, 32, data width of GPRs and writeback data
FIFO_DEPTH, 4, FPU result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst_l  in  1  reset; synchronous, active-high (1 = reset)
alu_wb_valid  in  1  ALU result valid this cycle
alu_wb_rd  in  5  ALU destination register
alu_wb_data  in  XLEN  ALU result
fpu_wb_valid  in  1  FPU result valid
fpu_wb_ready  out  1  FIFO can accept an FPU result
fpu_wb_rd  in  5  FPU destination register
fpu_wb_data  in  XLEN  FPU result
fpu_issue_valid  in  1  long-latency FPU op issued this cycle
fpu_issue_rd  in  5  destination of the issued FPU op
raddr0  in  5  GPR read address, port 0
raddr1  in  5  GPR read address, port 1
stall0  out  1  raddr0 targets a busy register
stall1  out  1  raddr1 targets a busy register
wen0  out  1  GPR write enable (registered)
waddr0  out  5  GPR write address (registered)
wd0  out  XLEN  GPR write data (registered)
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_l=1 at a clk edge):
  - wen0=0, waddr0=0, wd0=0.
  - FIFO emptied, so fifo_count=0; busy[31:1]=0.
  - fpu_wb_ready is forced to 0 while rst_l=1.
  - Reset mid-operation discards all buffered FPU results and pending busy bits.
- Write-port registers are updated every edge. wen0 is high for exactly one cycle per write.
- ALU path: alu_wb_valid=1 with rd!=0 in cycle N gives wen0=1, waddr0=alu_wb_rd, wd0=alu_wb_data in cycle N+1. An ALU write with rd=0 produces wen0=0 in N+1.
- FPU FIFO push: fpu_wb_valid & fpu_wb_ready. fpu_wb_ready = (fifo_count < FIFO_DEPTH); it does not depend on a same-cycle pop.
- FPU FIFO pop: head entry is popped in a cycle when fifo_count>0 and alu_wb_valid=0. The ALU always has priority; the FIFO only drains in cycles the ALU is idle.
- Popped entry drives the write port next cycle. If its rd=0, wen0 stays 0 but the pop still occurs.
- No FIFO bypass. Push in cycle N with an idle ALU gives wen0 in cycle N+2.
- Push and pop in the same cycle: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- A source flag wb_is_fpu is registered alongside wen0.
- Scoreboard set: fpu_issue_valid with rd!=0 sets busy[rd] at the edge. Issue to an already-busy register leaves it busy.
- Scoreboard clear: busy[waddr0] is cleared at the end of any cycle where wen0=1 and wb_is_fpu=1.
- Set and clear of the same register in the same cycle: set wins.
- ALU writes never alter busy bits. A WAW from the ALU onto a busy register is written normally.
- stall0 = (raddr0!=0) & busy[raddr0]; stall1 likewise. Both are combinational. Stall holds through the cycle the FPU write is on the port, so a read the cycle after sees the new value.
- In-order FPU results: FPU results are written in push order.

Test Plan:
- ALU write: alu_wb_valid=1, rd=5, data=0x0000_3C00 in cycle 1 -> cycle 2 wen0=1, waddr0=5, wd0=0x3C00; cycle 3 wen0=0. Repeat with rd=0 -> wen0 stays 0.
- FPU latency and scoreboard:
  - Stimulus: issue rd=7 in cycle 1; raddr0=7 in cycles 2-5; push rd=7, data=0x4200 in cycle 3; ALU idle.
  - Response: stall0=1 in cycles 2-4; wen0=1, waddr0=7 in cycle 5 with stall0 still 1; stall0=0 in cycle 6.
- Priority/backpressure:
  - Stimulus: ALU valid every cycle while FPU pushes 5 results.
  - Response: fifo_count reaches 4 and fpu_wb_ready=0. The 5th result is held until the ALU goes idle, after which the FIFO drains 1 per cycle in push order.
- Wrap-around: 10 FPU results pushed/popped continuously with ALU idle -> waddr0/wd0 sequence matches push order; fifo_count never exceeds 4.
- Scoreboard collision: fpu_issue_valid rd=9 in the same cycle that wen0=1, waddr0=9, wb_is_fpu=1 -> busy[9] remains 1 and stall for raddr1=9 stays 1.
- Mid-operation reset: 3 entries in FIFO with busy[3,4]=1, rst_l=1 for one cycle -> next cycle fifo_count=0, wen0=0, stall0=stall1=0; no buffered write ever appears.
